// File: rtl/acl2_spi_interface_if.sv
// rtl/acl2_spi_interface_if.sv - byte-request and SPI pin bundle for the ACL2 SPI byte engine
interface acl2_spi_interface_if;
    logic       begin_transmission;
    logic [7:0] send_data;
    logic       miso;
    logic       end_transmission;
    logic [7:0] received_data;
    logic       chip_select;
    logic       sclk;
    logic       mosi;

    // Engine side: consumes byte requests and MISO, produces results and SPI pins.
    modport slave (
        input  begin_transmission,
        input  send_data,
        input  miso,
        output end_transmission,
        output received_data,
        output chip_select,
        output sclk,
        output mosi
    );

    // Environment side: upstream requester plus the sensor's MISO.
    modport master (
        output begin_transmission,
        output send_data,
        output miso,
        input  end_transmission,
        input  received_data,
        input  chip_select,
        input  sclk,
        input  mosi
    );
endinterface

// File: rtl/acl2_spi_interface.sv
// rtl/acl2_spi_interface.sv - SPI mode-0 byte shifter with CS held across multi-byte transactions
// Optional ACL2_SPI_LOOPBACK_EN: RX shifter samples internal mosi instead of the miso pin.
module acl2_spi_interface #(
    parameter int CLK_DIV = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    acl2_spi_interface_if.slave        bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        LOW     = 3'd2,
        HIGH    = 3'd3,
        GAP     = 3'd4,
        CS_HOLD = 3'd5,
        CS_IDLE = 3'd6
    } state_t;

    localparam logic [7:0] HALF_MAX = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rd_q, rd_d;
    logic       cs_q, cs_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       et_q, et_d;
    logic       half_done;
    logic       rx_bit;

    assign half_done = (cnt_q == HALF_MAX);

`ifdef ACL2_SPI_LOOPBACK_EN
    assign rx_bit = mosi_q;
`else
    assign rx_bit = bus.miso;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            rd_q    <= 8'd0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            et_q    <= et_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (bus.begin_transmission) state_d = SETUP;
            SETUP, LOW:  if (half_done) state_d = HIGH;
            HIGH:        if (half_done) state_d = (bit_q == 3'd7) ? GAP : LOW;
            GAP:         if (half_done) state_d = bus.begin_transmission ? SETUP : CS_HOLD;
            CS_HOLD:     if (half_done) state_d = CS_IDLE;
            CS_IDLE:     if (half_done) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        rd_d   = rd_q;
        cs_d   = cs_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        et_d   = 1'b0;

        // Every non-idle state lasts exactly one half-period.
        if (state_q != IDLE) begin
            cnt_d = half_done ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.begin_transmission) begin
                    tx_d   = bus.send_data;
                    mosi_d = bus.send_data[7];
                    cs_d   = 1'b0;
                    bit_d  = 3'd0;
                    cnt_d  = 8'd0;
                end
            end
            SETUP, LOW: begin
                if (half_done) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], rx_bit};
                end
            end
            HIGH: begin
                if (half_done) begin
                    sclk_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                        bit_d  = bit_q + 3'd1;
                    end else begin
                        rd_d = rx_q;
                        et_d = 1'b1;
                    end
                end
            end
            GAP: begin
                // The master's late send_data update lands inside this window.
                if (half_done && bus.begin_transmission) begin
                    tx_d   = bus.send_data;
                    mosi_d = bus.send_data[7];
                    bit_d  = 3'd0;
                end
            end
            CS_HOLD: begin
                if (half_done) begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.end_transmission = et_q;
    assign bus.received_data    = rd_q;
    assign bus.chip_select      = cs_q;
    assign bus.sclk             = sclk_q;
    assign bus.mosi             = mosi_q;
endmodule

// File: tb/tb_acl2_spi_interface.sv
// tb/tb_acl2_spi_interface.sv - directed bench for acl2_spi_interface at CLK_DIV=4
module tb_acl2_spi_interface;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    acl2_spi_interface_if bus_if ();

    acl2_spi_interface #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int miso_base = 0;
    int et_cnt = 0;
    int cs_rise_cnt = 0;
    logic [7:0]  mosi_shift = 8'h00;
    logic [7:0]  miso_bytes [0:15];
    logic [31:0] miso_pos;

    always @(posedge clk) cyc++;

    // Sensor model: presents the current bit, advances after each SCLK rise; also logs MOSI.
    always @(posedge bus_if.sclk) begin
        mosi_shift = {mosi_shift[6:0], bus_if.mosi};
        rise_cnt++;
    end

    always @(negedge clk) if (bus_if.end_transmission === 1'b1) et_cnt++;
    always @(posedge bus_if.chip_select) cs_rise_cnt++;

    assign miso_pos    = 32'(rise_cnt - miso_base);
    assign bus_if.miso = miso_bytes[miso_pos[6:3]][~miso_pos[2:0]];

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] mi);
`ifdef ACL2_SPI_LOOPBACK_EN
        return tx;
`else
        return mi;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(input logic v, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.chip_select !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cs_bound", 32'(n < 500), 32'd1);
        t = cyc;
    endtask

    task automatic wait_et(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.end_transmission !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_et_bound", 32'(n < 500), 32'd1);
        t = cyc;
    endtask

    initial begin
        int t_cs, t_et, t_prev, t_hi, base_rise, base_et;
        for (int i = 0; i < 16; i++) miso_bytes[i] = 8'h00;
        bus_if.begin_transmission = 1'b0;
        bus_if.send_data = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(bus_if.chip_select), 32'd1);
        chk("rst_sclk", 32'(bus_if.sclk), 32'd0);
        chk("rst_mosi", 32'(bus_if.mosi), 32'd0);
        chk("rst_et", 32'(bus_if.end_transmission), 32'd0);
        chk("rst_rd", 32'(bus_if.received_data), 32'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0B, sensor returns A5
        miso_bytes[0] = 8'hA5;
        miso_base = rise_cnt;
        bus_if.send_data = 8'h0B;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        wait_et(t_et);
        bus_if.begin_transmission = 1'b0;
        chk("single_latency", 32'(t_et - t_cs), 32'd64);
        chk("single_rd", 32'(bus_if.received_data), 32'(exp_rx(8'h0B, 8'hA5)));
        chk("single_mosi", 32'(mosi_shift), 32'h0B);
        @(negedge clk);
        chk("single_et_width", 32'(bus_if.end_transmission), 32'd0);
        wait_cs(1'b1, t_hi);
        chk("single_cs_rise", 32'(t_hi - t_et), 32'd8);
        repeat (12) @(negedge clk);

        // Three-byte write 0A/20/2C
        base_rise = cs_rise_cnt;
        bus_if.send_data = 8'h0A;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        wait_et(t_prev);
        chk("wr0_mosi", 32'(mosi_shift), 32'h0A);
        @(negedge clk);
        bus_if.send_data = 8'h20;
        wait_et(t_et);
        chk("wr1_gap", 32'(t_et - t_prev), 32'd68);
        chk("wr1_mosi", 32'(mosi_shift), 32'h20);
        t_prev = t_et;
        @(negedge clk);
        bus_if.send_data = 8'h2C;
        wait_et(t_et);
        bus_if.begin_transmission = 1'b0;
        chk("wr2_gap", 32'(t_et - t_prev), 32'd68);
        chk("wr2_mosi", 32'(mosi_shift), 32'h2C);
        chk("wr_cs_held", 32'(cs_rise_cnt - base_rise), 32'd0);
        wait_cs(1'b1, t_hi);
        repeat (12) @(negedge clk);

        // Burst read: 0B, 0E, six dummies, sensor returns 01..06
        for (int i = 0; i < 6; i++) miso_bytes[i + 2] = 8'(i + 1);
        miso_base = rise_cnt;
        base_rise = cs_rise_cnt;
        bus_if.send_data = 8'h0B;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        wait_et(t_et);
        @(negedge clk);
        bus_if.send_data = 8'h0E;
        wait_et(t_et);
        @(negedge clk);
        bus_if.send_data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            wait_et(t_et);
            if (i == 5) bus_if.begin_transmission = 1'b0;
            chk("burst_rd", 32'(bus_if.received_data), 32'(exp_rx(8'h00, 8'(i + 1))));
            chk("burst_cs_low", 32'(bus_if.chip_select), 32'd0);
        end
        wait_cs(1'b1, t_hi);
        chk("burst_cs_rise_once", 32'(cs_rise_cnt - base_rise), 32'd1);
        repeat (12) @(negedge clk);

        // Mid-byte drop of begin_transmission and send_data change
        miso_bytes[0] = 8'h7E;
        miso_base = rise_cnt;
        base_et = et_cnt;
        bus_if.send_data = 8'h5A;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        repeat (20) @(negedge clk);
        bus_if.begin_transmission = 1'b0;
        bus_if.send_data = 8'hFF;
        wait_et(t_et);
        chk("mid_latency", 32'(t_et - t_cs), 32'd64);
        chk("mid_mosi", 32'(mosi_shift), 32'h5A);
        chk("mid_rd", 32'(bus_if.received_data), 32'(exp_rx(8'h5A, 8'h7E)));
        wait_cs(1'b1, t_hi);
        chk("mid_no_next", 32'(t_hi - t_et), 32'd8);
        chk("mid_et_count", 32'(et_cnt - base_et), 32'd1);
        repeat (12) @(negedge clk);

        // Reset asserted 30 cycles into a byte
        base_et = et_cnt;
        bus_if.send_data = 8'hC3;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_cs", 32'(bus_if.chip_select), 32'd1);
        chk("rstmid_sclk", 32'(bus_if.sclk), 32'd0);
        chk("rstmid_mosi", 32'(bus_if.mosi), 32'd0);
        chk("rstmid_rd", 32'(bus_if.received_data), 32'h00);
        repeat (3) @(negedge clk);
        bus_if.begin_transmission = 1'b0;
        rst = 1'b1;
        repeat (80) @(negedge clk);
        chk("rstmid_no_et", 32'(et_cnt - base_et), 32'd0);

        // Clean transfer after reset
        miso_bytes[0] = 8'h96;
        miso_base = rise_cnt;
        bus_if.send_data = 8'h71;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        wait_et(t_et);
        bus_if.begin_transmission = 1'b0;
        chk("post_latency", 32'(t_et - t_cs), 32'd64);
        chk("post_rd", 32'(bus_if.received_data), 32'(exp_rx(8'h71, 8'h96)));
        chk("post_mosi", 32'(mosi_shift), 32'h71);
        wait_cs(1'b1, t_hi);
        repeat (12) @(negedge clk);

        // Loopback byte 3C against a sensor returning C3
        miso_bytes[0] = 8'hC3;
        miso_base = rise_cnt;
        bus_if.send_data = 8'h3C;
        bus_if.begin_transmission = 1'b1;
        wait_cs(1'b0, t_cs);
        wait_et(t_et);
        bus_if.begin_transmission = 1'b0;
        chk("loop_rd", 32'(bus_if.received_data), 32'(exp_rx(8'h3C, 8'hC3)));
        wait_cs(1'b1, t_hi);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
